// File: rtl/dshot_pkg.sv
// Shared DSHOT constants, channel state encoding and counter sizing helper.
package dshot_pkg;

   localparam int DSHOT_VALUE_W  = 11;
   localparam int CMD_MOTOR_STOP = 0;
   localparam int CMD_SPIN_DIR_1 = 7;
   localparam int CMD_SPIN_DIR_2 = 8;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      FAILSAFE = 2'd2
   } chanState_t;

   // Bits needed to hold 0..lim inclusive, never below one bit.
   function automatic int cntW(input int lim);
      return (lim < 2) ? 1 : $clog2(lim + 1);
   endfunction

endpackage

// File: rtl/speed_channel.sv
// One motor channel: arming, throttle scaling, direction change and
// link-loss failsafe driven by accepted DSHOT frames.
module speed_channel
   import dshot_pkg::*;
#(
   parameter int OUT_W          = 8,
   parameter int TIMEOUT_CYCLES = 2400000,
   parameter int ARM_FRAMES     = 10,
   parameter int DIR_REPEAT     = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frameStb,
   input  logic [DSHOT_VALUE_W-1:0] frameValue,
   input  logic                     frameIsCmd,
   input  logic                     frameCrcOk,
   output logic [OUT_W-1:0]         speed,
   output logic                     dir,
   output logic                     armed,
   output logic                     failsafe
);

   localparam int ARM_W = cntW(ARM_FRAMES);
   localparam int DIR_W = cntW(DIR_REPEAT);
   localparam int TMO_W = cntW(TIMEOUT_CYCLES);
   localparam int SHIFT = DSHOT_VALUE_W - OUT_W;

   chanState_t       state;
   chanState_t       stateNext;
   logic [ARM_W-1:0] armCnt;
   logic [ARM_W-1:0] armCntNext;
   logic [DIR_W-1:0] dirCnt;
   logic [DIR_W-1:0] dirCntNext;
   logic [TMO_W-1:0] tmoCnt;
   logic [TMO_W-1:0] tmoCntNext;
   logic [OUT_W-1:0] speedNext;
   logic             dirNext;
   logic             prevDir;
   logic             prevDirNext;
   logic             prevDir2;
   logic             prevDir2Next;

   logic accept;
   logic isStop;
   logic isDir1;
   logic isDir2;
   logic isDirCmd;
   logic sameDir;
   int   armInc;
   int   dirInc;
   int   tmoInc;

   always_comb begin
      accept   = frameStb & frameCrcOk;
      isStop   = frameIsCmd &&
                 (frameValue == DSHOT_VALUE_W'(CMD_MOTOR_STOP));
      isDir1   = frameIsCmd &&
                 (frameValue == DSHOT_VALUE_W'(CMD_SPIN_DIR_1));
      isDir2   = frameIsCmd &&
                 (frameValue == DSHOT_VALUE_W'(CMD_SPIN_DIR_2));
      isDirCmd = isDir1 | isDir2;
      sameDir  = prevDir && (prevDir2 == isDir2);
      armInc   = int'(armCnt) + 1;
      dirInc   = sameDir ? int'(dirCnt) + 1 : 1;
      tmoInc   = int'(tmoCnt) + 1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= DISARMED;
         armCnt   <= '0;
         dirCnt   <= '0;
         tmoCnt   <= '0;
         speed    <= '0;
         dir      <= 1'b0;
         prevDir  <= 1'b0;
         prevDir2 <= 1'b0;
      end else begin
         state    <= stateNext;
         armCnt   <= armCntNext;
         dirCnt   <= dirCntNext;
         tmoCnt   <= tmoCntNext;
         speed    <= speedNext;
         dir      <= dirNext;
         prevDir  <= prevDirNext;
         prevDir2 <= prevDir2Next;
      end
   end

   always_comb begin
      stateNext    = state;
      armCntNext   = armCnt;
      dirCntNext   = dirCnt;
      tmoCntNext   = tmoCnt;
      speedNext    = speed;
      dirNext      = dir;
      prevDirNext  = prevDir;
      prevDir2Next = prevDir2;

      unique case (state)
         DISARMED, FAILSAFE: begin
            speedNext  = '0;
            tmoCntNext = '0;
            if (accept) begin
               stateNext = DISARMED;
               if (!isStop) begin
                  armCntNext = '0;
               end else if (armInc >= ARM_FRAMES) begin
                  stateNext  = ARMED;
                  armCntNext = '0;
               end else begin
                  armCntNext = ARM_W'(armInc);
               end
            end
         end
         ARMED: begin
            if (accept) begin
               tmoCntNext = '0;
               if (!frameIsCmd) begin
                  speedNext = OUT_W'(frameValue >> SHIFT);
               end else if (isStop) begin
                  speedNext = '0;
               end
            end else if (tmoInc >= TIMEOUT_CYCLES - 1) begin
               // A frame in the expiry cycle takes the branch above.
               stateNext  = FAILSAFE;
               speedNext  = '0;
               tmoCntNext = '0;
            end else begin
               tmoCntNext = TMO_W'(tmoInc);
            end
         end
         default: begin
            stateNext  = DISARMED;
            armCntNext = '0;
            tmoCntNext = '0;
            speedNext  = '0;
         end
      endcase

      if (accept) begin
         prevDirNext  = isDirCmd;
         prevDir2Next = isDir2;
         if (!isDirCmd) begin
            dirCntNext = '0;
         end else if (dirInc >= DIR_REPEAT) begin
            // Direction only flips with the motor stopped.
            if (state == ARMED && speed == '0) begin
               dirNext    = isDir2;
               dirCntNext = '0;
            end else begin
               dirCntNext = DIR_W'(DIR_REPEAT);
            end
         end else begin
            dirCntNext = DIR_W'(dirInc);
         end
      end
   end

   assign armed    = (state == ARMED);
   assign failsafe = (state == FAILSAFE);

endmodule

// File: rtl/multi_speed_handler.sv
// Bank of independent DSHOT speed channels sharing one clock and reset.
module multi_speed_handler
   import dshot_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int OUT_W          = 8,
   parameter int TIMEOUT_CYCLES = 2400000,
   parameter int ARM_FRAMES     = 10,
   parameter int DIR_REPEAT     = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_CH-1:0]               frame_stb,
   input  logic [NUM_CH*DSHOT_VALUE_W-1:0] frame_value,
   input  logic [NUM_CH-1:0]               frame_is_cmd,
   input  logic [NUM_CH-1:0]               frame_crc_ok,
   output logic [NUM_CH*OUT_W-1:0]         speed_out,
   output logic [NUM_CH-1:0]               dir_out,
   output logic [NUM_CH-1:0]               armed,
   output logic [NUM_CH-1:0]               failsafe
);

   for (genvar i = 0; i < NUM_CH; i++) begin : gCh
      speed_channel #(
         .OUT_W          (OUT_W),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .ARM_FRAMES     (ARM_FRAMES),
         .DIR_REPEAT     (DIR_REPEAT)
      ) uCh (
         .clk        (clk),
         .rst        (rst),
         .frameStb   (frame_stb[i]),
         .frameValue (frame_value[DSHOT_VALUE_W*i +: DSHOT_VALUE_W]),
         .frameIsCmd (frame_is_cmd[i]),
         .frameCrcOk (frame_crc_ok[i]),
         .speed      (speed_out[OUT_W*i +: OUT_W]),
         .dir        (dir_out[i]),
         .armed      (armed[i]),
         .failsafe   (failsafe[i])
      );
   end

endmodule
